ex_div: RTL

EX_DIV -- requirements
Module: ex_div

---
 rtl/ex_div_pkg.sv | 22 ++
 rtl/ex_div.sv | 127 ++++++++++++
 2 files changed

// File: rtl/ex_div_pkg.sv
// Shared divider definitions: FSM state encodings, handshake levels and the HI/LO bus width.
package ex_div_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam int   DoubleRegBus      = 64;

  // Magnitude of an operand; only negative values in signed mode are flipped.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for the EX stage: 32 shift-subtract steps, signed fixup on exit,
// result held in END until the pipeline drops start_i.
module ex_div
  import ex_div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    signed_i,
  input  logic [31:0]             opdata1_i,
  input  logic [31:0]             opdata2_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic                    stallreq_o
);

  div_state_t              state_reg, state_next;
  logic [5:0]              cnt_reg, cnt_next;
  logic [64:0]             work_reg, work_next;
  logic [31:0]             divisor_reg, divisor_next;
  logic                    negq_reg, negq_next;
  logic                    negr_reg, negr_next;
  logic [DoubleRegBus-1:0] result_reg, result_next;
  logic                    ready_reg, ready_next;

  // Working register: remainder in [64:32], dividend/quotient bits in [31:0].
  logic [64:0] shifted;
  logic [32:0] trial;
  logic        fits;
  logic [64:0] step;
  logic [31:0] quot, rem, fix_q, fix_r;

  always_comb begin
    shifted = work_reg << 1;
    fits    = shifted[64:32] >= {1'b0, divisor_reg};
    trial   = shifted[64:32] - {1'b0, divisor_reg};
    step    = fits ? {trial, shifted[31:1], 1'b1} : shifted;
    quot    = step[31:0];
    rem     = step[63:32];
    fix_q   = negq_reg ? -quot : quot;
    fix_r   = negr_reg ? -rem : rem;
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    work_next    = work_reg;
    divisor_next = divisor_reg;
    negq_next    = negq_reg;
    negr_next    = negr_reg;
    result_next  = result_reg;
    ready_next   = ready_reg;
    case (state_reg)
      DivFree: begin
        result_next = '0;
        ready_next  = DivResultNotReady;
        if (start_i == DivStart && !annul_i) begin
          divisor_next = abs32(opdata2_i, signed_i);
          negq_next    = signed_i & (opdata1_i[31] ^ opdata2_i[31]);
          negr_next    = signed_i & opdata1_i[31];
          work_next    = {33'b0, abs32(opdata1_i, signed_i)};
          cnt_next     = 6'd0;
          state_next   = (opdata2_i == 32'd0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (annul_i) begin
          state_next = DivFree;
        end else begin
          state_next  = DivEnd;
          result_next = '0;
          ready_next  = DivResultReady;
        end
      end
      DivOn: begin
        if (annul_i) begin
          state_next = DivFree;
        end else begin
          work_next = step;
          cnt_next  = cnt_reg + 6'd1;
          // The 32nd step lands directly in END so ready_o rises 33 cycles after acceptance.
          if (cnt_reg == 6'd31) begin
            state_next  = DivEnd;
            result_next = {fix_r, fix_q};
            ready_next  = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_next  = DivFree;
          result_next = '0;
          ready_next  = DivResultNotReady;
        end
      end
      default: state_next = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= DivFree;
      cnt_reg     <= 6'd0;
      work_reg    <= '0;
      divisor_reg <= '0;
      negq_reg    <= 1'b0;
      negr_reg    <= 1'b0;
      result_reg  <= '0;
      ready_reg   <= DivResultNotReady;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      work_reg    <= work_next;
      divisor_reg <= divisor_next;
      negq_reg    <= negq_next;
      negr_reg    <= negr_next;
      result_reg  <= result_next;
      ready_reg   <= ready_next;
    end
  end

  assign result_o   = result_reg;
  assign ready_o    = ready_reg;
  assign stallreq_o = start_i & ~ready_reg;

endmodule
